// File: rtl/riscv_pkg.sv
// Shared definitions for the decode-stage issue logic: opcode values,
// operand forward-select encodings and the in-flight destination slot.
package riscv_pkg;

  // Base-ISA major opcodes recognised by the decode stage
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operand source for the instruction sitting in EX
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file (write-through covers WB)
  localparam logic [1:0] FWD_MEM = 2'b01;  // EX/MEM pipeline register
  localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB pipeline register

  // One in-flight destination. Invalid slots are kept all-zero, so a
  // slot is either empty or names a real (non-x0) destination register.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       is_load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{v: 1'b0, rd: 5'd0, is_load: 1'b0};

  // Select the freshest producer of a source register for an instruction
  // about to enter EX. `ex` becomes the EX/MEM producer and `mem` the
  // MEM/WB producer one edge later. A load still in EX cannot forward
  // (its data does not exist yet); that case is covered by the load-use
  // stall, so here it simply falls through to the older slot.
  function automatic logic [1:0] fwd_select(input logic       use_rs,
                                            input logic [4:0] rs,
                                            input slot_t      ex,
                                            input slot_t      mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_rs && (rs != 5'd0)) begin
      if (ex.v && !ex.is_load && (ex.rd == rs)) begin
        sel = FWD_MEM;
      end else if (mem.v && (mem.rd == rs)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/id_use_decode.sv
// Opcode classifier: which source registers an instruction reads, whether
// it writes rd, and whether it is a load. Unknown opcodes behave as NOPs.
module id_use_decode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       use_rs1_o,
  output logic       use_rs2_o,
  output logic       writes_rd_o,
  output logic       is_load_o
);

  // Per-class operand usage table
  always_comb begin
    use_rs1_o   = 1'b0;
    use_rs2_o   = 1'b0;
    writes_rd_o = 1'b0;
    is_load_o   = 1'b0;
    case (opcode_i)
      OP_R: begin
        use_rs1_o   = 1'b1;
        use_rs2_o   = 1'b1;
        writes_rd_o = 1'b1;
      end
      OP_IMM: begin
        use_rs1_o   = 1'b1;
        writes_rd_o = 1'b1;
      end
      OP_LOAD: begin
        use_rs1_o   = 1'b1;
        writes_rd_o = 1'b1;
        is_load_o   = 1'b1;
      end
      OP_STORE: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      OP_BRANCH: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      OP_JALR: begin
        use_rs1_o   = 1'b1;
        writes_rd_o = 1'b1;
      end
      OP_JAL: begin
        writes_rd_o = 1'b1;
      end
      OP_LUI: begin
        writes_rd_o = 1'b1;
      end
      OP_AUIPC: begin
        writes_rd_o = 1'b1;
      end
      default: begin
        use_rs1_o   = 1'b0;
        use_rs2_o   = 1'b0;
        writes_rd_o = 1'b0;
        is_load_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller. Tracks destinations in EX/MEM/WB, stalls
// ID for one cycle on a load-use dependency, bubbles EX when nothing
// issues, registers ALU forward selects alongside the EX entry and counts
// load-use stall cycles (saturating).
//
// Handshake: id_ready means ID may advance this cycle; issue = id_valid &
// id_ready & !flush, and an issued instruction occupies EX after the next
// rising edge. ex_hold freezes everything (including flush handling).
module id_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_hold,
  input  logic             flush,
  output logic             id_ready,
  output logic             issue,
  output logic             ex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  logic use_rs1;
  logic use_rs2;
  logic writes_rd;
  logic is_load;

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d;
  slot_t id_entry;

  logic             luse;
  logic             ex_bubble_q, ex_bubble_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  id_use_decode u_decode (
    .opcode_i    (id_opcode),
    .use_rs1_o   (use_rs1),
    .use_rs2_o   (use_rs2),
    .writes_rd_o (writes_rd),
    .is_load_o   (is_load)
  );

  // Load in EX whose result the ID instruction needs: data not ready yet
  always_comb begin
    luse = 1'b0;
    if (id_valid && ex_q.v && ex_q.is_load && (ex_q.rd != 5'd0)) begin
      luse = (use_rs1 && (id_rs1 == ex_q.rd)) ||
             (use_rs2 && (id_rs2 == ex_q.rd));
    end
  end

  assign id_ready = !ex_hold && !luse;
  assign issue    = id_valid && id_ready && !flush;

  // Tracker entry for the ID instruction; writes to x0 track as empty
  always_comb begin
    id_entry = SLOT_EMPTY;
    if (writes_rd && (id_rd != 5'd0)) begin
      id_entry = '{v: 1'b1, rd: id_rd, is_load: is_load};
    end
  end

  // Next EX contents, forward selects, bubble flag and stall count
  always_comb begin
    ex_d        = issue ? id_entry : SLOT_EMPTY;
    ex_bubble_d = !issue;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    if (issue) begin
      fwd_a_d = fwd_select(use_rs1, id_rs1, ex_q, mem_q);
      fwd_b_d = fwd_select(use_rs2, id_rs2, ex_q, mem_q);
    end
    stall_cnt_d = stall_cnt_q;
    if (luse && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Pipeline shift and registered outputs; ex_hold freezes all of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= SLOT_EMPTY;
      mem_q       <= SLOT_EMPTY;
      wb_q        <= SLOT_EMPTY;
      ex_bubble_q <= 1'b1;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else if (!ex_hold) begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      ex_bubble_q <= ex_bubble_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_bubble = ex_bubble_q;
  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

  // Slot invariant: empty slots are all-zero, valid slots never name x0.
  // The WB slot is tracked for completeness; the write-through register
  // file means it never needs a forward path.
  a_ex_slot:  assert property (@(posedge clk) disable iff (!rst_n)
                (ex_q.v && ex_q.rd != 5'd0) || (ex_q == SLOT_EMPTY));
  a_mem_slot: assert property (@(posedge clk) disable iff (!rst_n)
                (mem_q.v && mem_q.rd != 5'd0) || (mem_q == SLOT_EMPTY));
  a_wb_slot:  assert property (@(posedge clk) disable iff (!rst_n)
                (wb_q.v && wb_q.rd != 5'd0) || (wb_q == SLOT_EMPTY));

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: directed hazard scenarios then random traffic,
// checked against a cycle model of in-flight producers.
module tb_id_hazard_ctrl;
  import riscv_pkg::*;

  localparam int CNT_W = 16;
  localparam int W     = 7 + CNT_W;  // ready, issue, bubble, fwd_a, fwd_b, cnt

  logic             clk;
  logic             rst_n;
  logic             id_valid;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rd;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_hold;
  logic             flush;
  logic             id_ready;
  logic             issue;
  logic             ex_bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt;

  id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .id_rd     (id_rd),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .ex_hold   (ex_hold),
    .flush     (flush),
    .id_ready  (id_ready),
    .issue     (issue),
    .ex_bubble (ex_bubble),
    .fwd_a_sel (fwd_a_sel),
    .fwd_b_sel (fwd_b_sel),
    .stall_cnt (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instructions that have entered EX, youngest first: [0]=EX, [1]=MEM, [2]=WB.
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } m_slot_t;

  m_slot_t m_pipe[3];
  bit      m_bubble;
  int      m_fa;
  int      m_fb;
  int      m_cnt;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '{v: 1'b0, rd: 0, ld: 1'b0};
    m_bubble = 1'b1;
    m_fa     = 0;
    m_fb     = 0;
    m_cnt    = 0;
  endfunction

  // Register usage from the instruction-set table
  function automatic void classify(input logic [6:0] op, output bit u1, output bit u2,
                                   output bit wr, output bit ld);
    u1 = 0; u2 = 0; wr = 0; ld = 0;
    if (op == OP_R || op == OP_STORE || op == OP_BRANCH) begin u1 = 1; u2 = 1; end
    if (op == OP_IMM || op == OP_LOAD || op == OP_JALR) u1 = 1;
    if (op == OP_R || op == OP_IMM || op == OP_LOAD || op == OP_JALR ||
        op == OP_JAL || op == OP_LUI || op == OP_AUIPC) wr = 1;
    ld = (op == OP_LOAD);
  endfunction

  // Where the operand comes from when the consumer reaches EX: one ahead
  // (non-load) -> EX/MEM, two ahead -> MEM/WB, otherwise register file.
  function automatic int m_fwd(input bit u, input int rs);
    if (!u || rs == 0) return 0;
    if (m_pipe[0].v && m_pipe[0].rd == rs && !m_pipe[0].ld) return 1;
    if (m_pipe[1].v && m_pipe[1].rd == rs) return 2;
    return 0;
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle, record what the DUT must show during it, then advance
  // the model to the state after the following rising edge.
  task automatic step(input bit v, input logic [6:0] op, input int rd, input int rs1,
                      input int rs2, input bit hold, input bit fl, output bit iss_o);
    bit u1, u2, wr, ld, luse, rdy, iss;
    @(posedge clk);
    #1;
    id_valid  = v;
    id_opcode = op;
    id_rd     = 5'(rd);
    id_rs1    = 5'(rs1);
    id_rs2    = 5'(rs2);
    ex_hold   = hold;
    flush     = fl;
    classify(op, u1, u2, wr, ld);
    luse = v && m_pipe[0].v && m_pipe[0].ld &&
           ((u1 && rs1 == m_pipe[0].rd) || (u2 && rs2 == m_pipe[0].rd));
    rdy  = !hold && !luse;
    iss  = v && rdy && !fl;
    exp_q.push_back({rdy, iss, m_bubble, 2'(m_fa), 2'(m_fb), CNT_W'(m_cnt)});
    if (!hold) begin
      if (luse && !fl && m_cnt < CNT_MAX) m_cnt++;
      m_fa     = iss ? m_fwd(u1, rs1) : 0;
      m_fb     = iss ? m_fwd(u2, rs2) : 0;
      m_bubble = !iss;
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      if (iss && wr && rd != 0) m_pipe[0] = '{v: 1'b1, rd: rd, ld: ld};
      else                      m_pipe[0] = '{v: 1'b0, rd: 0, ld: 1'b0};
    end
    iss_o = iss;
  endtask

  task automatic idle();
    bit iss;
    step(1'b0, 7'h00, 0, 0, 0, 1'b0, 1'b0, iss);
  endtask

  // Present one instruction until it issues (a load-use costs one cycle)
  task automatic send(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    bit iss;
    int n = 0;
    do begin
      step(1'b1, op, rd, rs1, rs2, 1'b0, 1'b0, iss);
      n++;
    end while (!iss && n < 8);
    chk("issue_within_budget", int'(iss), 1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("id_ready",  int'(id_ready),  int'(e[W-1]));
      chk("issue",     int'(issue),     int'(e[W-2]));
      chk("ex_bubble", int'(ex_bubble), int'(e[W-3]));
      chk("fwd_a_sel", int'(fwd_a_sel), int'(e[W-4 -: 2]));
      chk("fwd_b_sel", int'(fwd_b_sel), int'(e[W-6 -: 2]));
      chk("stall_cnt", int'(stall_cnt), int'(e[CNT_W-1:0]));
    end
  end

  // ---------------- stimulus ----------------
  logic [6:0] ops[10];

  initial begin
    bit iss;
    bit have;
    logic [6:0] c_op;
    int c_rd, c_rs1, c_rs2;

    ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL, OP_LUI,
            OP_AUIPC, 7'h0F};
    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_rd = '0; id_rs1 = '0;
    id_rs2 = '0; ex_hold = 1'b0; flush = 1'b0;
    m_reset();
    #22;
    chk("reset_bubble", int'(ex_bubble), 1);
    chk("reset_fwd_a",  int'(fwd_a_sel), 0);
    chk("reset_fwd_b",  int'(fwd_b_sel), 0);
    chk("reset_cnt",    int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back dependency: EX/MEM forward on rs1
    send(OP_R, 3, 1, 2);
    send(OP_R, 4, 3, 1);
    idle(); idle();

    // producer two ahead: MEM/WB forward; x0 never forwards
    send(OP_R, 3, 1, 2);
    send(OP_IMM, 0, 0, 0);
    send(OP_R, 5, 0, 3);
    idle(); idle();

    // load-use: one stall, then both operands from MEM/WB
    send(OP_LOAD, 6, 1, 0);
    send(OP_R, 7, 6, 6);
    idle(); idle();

    // load to x0 and lui after load: no stall
    send(OP_LOAD, 0, 1, 0);
    send(OP_R, 7, 0, 0);
    send(OP_LOAD, 6, 1, 0);
    send(OP_LUI, 6, 0, 0);
    idle(); idle();

    // flush on top of a load-use, then a three-cycle hold mid-stream
    send(OP_LOAD, 6, 1, 0);
    step(1'b1, OP_R, 7, 6, 6, 1'b0, 1'b1, iss);
    send(OP_R, 7, 6, 6);
    send(OP_R, 3, 1, 2);
    for (int i = 0; i < 3; i++) step(1'b1, OP_R, 4, 3, 1, 1'b1, (i == 1), iss);
    send(OP_R, 4, 3, 1);
    idle();

    // async reset between edges with non-reset state in flight
    send(OP_LOAD, 6, 1, 0);
    send(OP_R, 7, 6, 6);
    send(OP_R, 8, 7, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    id_valid = 1'b0; ex_hold = 1'b0; flush = 1'b0;
    #1;
    chk("async_rst_bubble", int'(ex_bubble), 1);
    chk("async_rst_fwd_a",  int'(fwd_a_sel), 0);
    chk("async_rst_fwd_b",  int'(fwd_b_sel), 0);
    chk("async_rst_cnt",    int'(stall_cnt), 0);
    m_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // counter saturation
    idle();
    @(negedge clk);
    #2;
    force dut.stall_cnt_q = {CNT_W{1'b1}};
    #1;
    release dut.stall_cnt_q;
    m_cnt = CNT_MAX;
    send(OP_LOAD, 6, 1, 0);
    send(OP_R, 7, 6, 6);
    idle(); idle();

    // random traffic; ID keeps its instruction until issued or flushed
    m_cnt = CNT_MAX;  // still saturated from above; reset to count afresh
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    id_valid = 1'b0; ex_hold = 1'b0; flush = 1'b0;
    m_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    have = 1'b0;
    c_op = OP_R; c_rd = 0; c_rs1 = 0; c_rs2 = 0;
    for (int n = 0; n < 500; n++) begin
      bit v, h, f;
      if (!have) begin
        c_op  = ops[$urandom_range(0, 9)];
        c_rd  = $urandom_range(0, 7);
        c_rs1 = $urandom_range(0, 7);
        c_rs2 = $urandom_range(0, 7);
      end
      v = ($urandom_range(0, 9) < 8);
      h = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 11) == 0);
      step(v, c_op, c_rd, c_rs1, c_rs2, h, f, iss);
      have = v && !iss && !(f && !h);
    end
    idle(); idle();
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "time limit");
  end

endmodule
